// File: rtl/a2d_pkg.sv
// Shared types and constants for the A2D SPI responder.
//   resp_state_t : responder state machine encoding
//   FRAME_BITS   : SPI command/response frame length
//   CMD_CH_*     : channel field position inside a command frame
//   DATA_BITS    : width of one A2D channel value
//   ch_pick()    : selects one channel value from the packed channel bus
package a2d_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    SHIFT
  } resp_state_t;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned CMD_CH_MSB = 13;
  localparam int unsigned CMD_CH_LSB = 11;
  localparam int unsigned DATA_BITS  = 12;
  localparam int unsigned NUM_CH     = 8;
  localparam int unsigned CH_W       = CMD_CH_MSB - CMD_CH_LSB + 1;
  localparam int unsigned CNT_W      = 5;

  function automatic logic [DATA_BITS-1:0] ch_pick(
    input logic [NUM_CH*DATA_BITS-1:0] bus,
    input logic [CH_W-1:0]             sel
  );
    logic [DATA_BITS-1:0] val;
    val = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (sel == CH_W'(i)) begin
        val = bus[i*DATA_BITS +: DATA_BITS];
      end
    end
    return val;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Synchronizer for one asynchronous SPI line followed by an edge-detect flop.
//   clk, rst_n : system clock, asynchronous active-low reset
//   d_i        : raw asynchronous input
//   rise_o     : one-clk pulse when the synchronized level goes 0->1
//   fall_o     : one-clk pulse when the synchronized level goes 1->0
// RST_VAL sets the level the chain assumes during reset.
module spi_sync_edge
  import a2d_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RST_VAL     = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   edge_q, edge_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
    edge_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      edge_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      edge_q <= edge_d;
    end
  end

  assign rise_o =  sync_q[SYNC_STAGES-1] & ~edge_q;
  assign fall_o = ~sync_q[SYNC_STAGES-1] &  edge_q;

endmodule

// File: rtl/a2d_spi_resp.sv
// SPI responder emulating an 8-channel 12-bit A2D (ADC128S style).
// Each 16-bit frame returns the channel addressed by the previous command.
//   clk, rst_n : system clock, asynchronous active-low reset
//   SS_n       : slave select from master, active low
//   SCLK       : SPI clock, idles high; master shifts on fall, samples on rise
//   MOSI       : command data from master
//   MISO       : response data (tx_shift MSB while a frame is open, else 0)
//   ch_data    : eight 12-bit channel values, channel n at [12n+11:12n]
//   ch_sel     : channel latched by the last complete 16-bit command
//   cmd_vld    : one-clk pulse when a complete command is latched
//   frame_err  : one-clk pulse when a frame ends with a bit count other than 16
module a2d_spi_resp
  import a2d_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        SS_n,
  input  logic                        SCLK,
  input  logic                        MOSI,
  output logic                        MISO,
  input  logic [NUM_CH*DATA_BITS-1:0] ch_data,
  output logic [CH_W-1:0]             ch_sel,
  output logic                        cmd_vld,
  output logic                        frame_err
);

  // Only bits [13:0] of the received frame can reach the channel field,
  // so the receive shifter stops there; the low bits line up unchanged.
  localparam int unsigned RX_W = CMD_CH_MSB + 1;

  logic sclk_rise, sclk_fall;
  logic ss_rise, ss_fall;

  // SS_n chain resets to "selected" so a low SS_n at reset release produces
  // no fall pulse; the block then waits for a genuine SS_n fall.
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_ss_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (SS_n),
    .rise_o (ss_rise),
    .fall_o (ss_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (SCLK),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  // MOSI takes the same number of stages, so its last stage holds the value
  // captured alongside the SCLK sample that produced sclk_rise.
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   mosi_s;

  assign mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];

  resp_state_t           state_q, state_d;
  logic [FRAME_BITS-1:0] tx_q, tx_d;
  logic [RX_W-1:0]       rx_q, rx_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [CH_W-1:0]       ch_sel_q, ch_sel_d;
  logic                  cmd_vld_q, cmd_vld_d;
  logic                  frame_err_q, frame_err_d;
  logic                  miso_q, miso_d;

  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    bit_cnt_d   = bit_cnt_q;
    ch_sel_d    = ch_sel_q;
    cmd_vld_d   = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          tx_d      = {{(FRAME_BITS-DATA_BITS){1'b0}}, ch_pick(ch_data, ch_sel_q)};
          rx_d      = '0;
          bit_cnt_d = '0;
          state_d   = ARMED;
        end
      end

      // The front-porch SCLK fall arrives here and is deliberately ignored,
      // keeping the MSB on MISO for the first rising edge.
      ARMED: begin
        if (ss_rise) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end else if (sclk_rise) begin
          rx_d      = {rx_q[RX_W-2:0], mosi_s};
          bit_cnt_d = bit_cnt_q + 1'b1;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        if (ss_rise) begin
          state_d = IDLE;
          if (bit_cnt_q == CNT_W'(FRAME_BITS)) begin
            ch_sel_d  = rx_q[CMD_CH_MSB:CMD_CH_LSB];
            cmd_vld_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          if (sclk_rise) begin
            rx_d = {rx_q[RX_W-2:0], mosi_s};
            if (bit_cnt_q != '1) begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
          if (sclk_fall) begin
            tx_d = {tx_q[FRAME_BITS-2:0], 1'b0};
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Outside IDLE the synchronized SS_n is low, so this gates MISO to 0
    // whenever the frame is closed.
    miso_d = (state_d != IDLE) ? tx_d[FRAME_BITS-1] : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_sync_q <= '0;
      state_q     <= IDLE;
      tx_q        <= '0;
      rx_q        <= '0;
      bit_cnt_q   <= '0;
      ch_sel_q    <= '0;
      cmd_vld_q   <= 1'b0;
      frame_err_q <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      mosi_sync_q <= mosi_sync_d;
      state_q     <= state_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      bit_cnt_q   <= bit_cnt_d;
      ch_sel_q    <= ch_sel_d;
      cmd_vld_q   <= cmd_vld_d;
      frame_err_q <= frame_err_d;
      miso_q      <= miso_d;
    end
  end

  assign MISO      = miso_q;
  assign ch_sel    = ch_sel_q;
  assign cmd_vld   = cmd_vld_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Directed bench for a2d_spi_resp: a table of SPI frames with hand-computed
// responses, followed by snapshot and mid-frame reset sequences.
module tb_a2d_spi_resp;

  localparam int H = 8;  // SCLK half period in clk cycles

  logic        clk = 1'b0;
  logic        rst_n;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;
  logic [95:0] ch_data;
  logic [2:0]  ch_sel;
  logic        cmd_vld;
  logic        frame_err;

  a2d_spi_resp #(.SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .SS_n      (SS_n),
    .SCLK      (SCLK),
    .MOSI      (MOSI),
    .MISO      (MISO),
    .ch_data   (ch_data),
    .ch_sel    (ch_sel),
    .cmd_vld   (cmd_vld),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int n_vld = 0;
  int n_err = 0;

  always @(posedge clk) begin
    if (cmd_vld === 1'b1)   n_vld++;
    if (frame_err === 1'b1) n_err++;
  end

  typedef struct {
    logic [15:0] cmd;
    int          nbits;
    logic [15:0] resp;
    logic [2:0]  sel;
    int          vld;
    int          err;
  } vec_t;

  vec_t vecs [15];

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_ch(input int ch, input logic [11:0] v);
    ch_data[ch*12 +: 12] = v;
  endtask

  task automatic spi_bit(input logic b, output logic m);
    SCLK = 1'b0;
    MOSI = b;
    wait_clk(H);
    m    = MISO;
    SCLK = 1'b1;
    wait_clk(H);
  endtask

  task automatic spi_frame(input logic [15:0] cmd, input int nbits, input int chg_bit,
                           input logic [11:0] chg_val, output logic [15:0] resp);
    logic [15:0] c;
    logic        m;
    c    = cmd;
    resp = '0;
    SS_n = 1'b0;
    wait_clk(H);
    for (int i = 0; i < nbits; i++) begin
      if (i == chg_bit) set_ch(1, chg_val);
      spi_bit(c[15], m);
      c    = {c[14:0], 1'b0};
      resp = {resp[14:0], m};
    end
    wait_clk(H);
    SS_n = 1'b1;
    wait_clk(2*H);
  endtask

  task automatic run_frame(input string tag, input logic [15:0] cmd, input int nbits,
                           input int chg_bit, input logic [11:0] chg_val,
                           input logic [15:0] exp_resp, input logic [2:0] exp_sel,
                           input int exp_vld, input int exp_err);
    int          v0, e0;
    logic [15:0] resp;
    v0 = n_vld;
    e0 = n_err;
    spi_frame(cmd, nbits, chg_bit, chg_val, resp);
    check($sformatf("%s resp", tag), 32'(resp), 32'(exp_resp));
    check($sformatf("%s ch_sel", tag), 32'(ch_sel), 32'(exp_sel));
    check($sformatf("%s cmd_vld pulses", tag), 32'(n_vld - v0), 32'(exp_vld));
    check($sformatf("%s frame_err pulses", tag), 32'(n_err - e0), 32'(exp_err));
    check($sformatf("%s idle MISO", tag), 32'(MISO), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] c;
    logic        m;
    logic        miso_or;
    int          v0, e0;

    // ch0..ch7 response values
    ch_data = '0;
    set_ch(0, 12'hABC); set_ch(1, 12'h123); set_ch(2, 12'h222); set_ch(3, 12'h456);
    set_ch(4, 12'hFFF); set_ch(5, 12'h555); set_ch(6, 12'h666); set_ch(7, 12'h5A5);

    //            cmd       bits  resp      sel   vld err
    vecs[0]  = '{16'h0800, 16, 16'h0ABC, 3'd1, 1, 0};  // first frame returns ch0
    vecs[1]  = '{16'h1800, 16, 16'h0123, 3'd3, 1, 0};
    vecs[2]  = '{16'h0000, 16, 16'h0456, 3'd0, 1, 0};
    vecs[3]  = '{16'h0800, 16, 16'h0ABC, 3'd1, 1, 0};
    vecs[4]  = '{16'h1800, 16, 16'h0123, 3'd3, 1, 0};
    vecs[5]  = '{16'h2000, 16, 16'h0456, 3'd4, 1, 0};
    vecs[6]  = '{16'h0000, 16, 16'h0FFF, 3'd0, 1, 0};
    vecs[7]  = '{16'hE7FF, 16, 16'h0ABC, 3'd4, 1, 0};  // non-channel bits ignored
    vecs[8]  = '{16'hFFFF, 16, 16'h0FFF, 3'd7, 1, 0};
    vecs[9]  = '{16'h0000, 16, 16'h05A5, 3'd0, 1, 0};
    vecs[10] = '{16'h1800,  9, 16'h0015, 3'd0, 0, 1};  // abort after 9 rises
    vecs[11] = '{16'h2000, 16, 16'h0ABC, 3'd4, 1, 0};
    vecs[12] = '{16'h0800, 17, 16'h1FFE, 3'd4, 0, 1};  // one bit too many
    vecs[13] = '{16'h0000,  0, 16'h0000, 3'd4, 0, 1};  // SS pulse, no SCLK
    vecs[14] = '{16'h0000, 16, 16'h0FFF, 3'd0, 1, 0};

    rst_n = 1'b0;
    SS_n  = 1'b1;
    SCLK  = 1'b1;
    MOSI  = 1'b0;
    wait_clk(3);
    check("reset MISO", 32'(MISO), 32'd0);
    check("reset ch_sel", 32'(ch_sel), 32'd0);
    check("reset cmd_vld", 32'(cmd_vld), 32'd0);
    check("reset frame_err", 32'(frame_err), 32'd0);
    rst_n = 1'b1;
    wait_clk(2*H);

    for (int i = 0; i < 15; i++) begin
      run_frame($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].nbits, -1, 12'h000,
                vecs[i].resp, vecs[i].sel, vecs[i].vld, vecs[i].err);
    end

    // Snapshot: ch1 changes after bit 4 of a frame that returns ch1.
    run_frame("snap_pre", 16'h0800, 16, -1, 12'h000, 16'h0ABC, 3'd1, 1, 0);
    run_frame("snap_cur", 16'h0800, 16, 4, 12'h777, 16'h0123, 3'd1, 1, 0);
    run_frame("snap_next", 16'h2000, 16, -1, 12'h000, 16'h0777, 3'd4, 1, 0);

    // Mid-frame reset while ch_sel=4 (ch4=FFF is being returned).
    v0   = n_vld;
    e0   = n_err;
    c    = 16'h0800;
    SS_n = 1'b0;
    wait_clk(H);
    for (int i = 0; i < 6; i++) begin
      spi_bit(c[15], m);
      c = {c[14:0], 1'b0};
    end
    check("pre-reset MISO", 32'(MISO), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async reset MISO", 32'(MISO), 32'd0);
    check("async reset ch_sel", 32'(ch_sel), 32'd0);
    wait_clk(2);
    rst_n   = 1'b1;
    miso_or = 1'b0;
    for (int i = 6; i < 16; i++) begin
      spi_bit(c[15], m);
      c       = {c[14:0], 1'b0};
      miso_or = miso_or | m;
    end
    wait_clk(H);
    SS_n = 1'b1;
    wait_clk(2*H);
    check("post-reset frame MISO", 32'(miso_or), 32'd0);
    check("post-reset frame cmd_vld", 32'(n_vld - v0), 32'd0);
    check("post-reset frame frame_err", 32'(n_err - e0), 32'd0);
    check("post-reset frame ch_sel", 32'(ch_sel), 32'd0);
    run_frame("after_reset", 16'h0800, 16, -1, 12'h000, 16'h0ABC, 3'd1, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
